// File: rtl/sdram_read_arbiter_pkg.sv
// Shared constants, FSM state type and sizing helper for the SDRAM read arbiter.
package sdram_read_arbiter_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_read_arbiter_if.sv
// Requester-side and memory-channel signals of the SDRAM read arbiter.
// slave: the arbiter's view; master: the surrounding caches and memory arbiter.
interface sdram_read_arbiter_if
  import sdram_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SZ_W    = 4
);

  logic [NUM_REQ-1:0]             rq_req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] rq_addr;
  logic [NUM_REQ-1:0][SZ_W-1:0]   rq_size;
  logic [NUM_REQ-1:0]             rq_valid;
  logic [DATA_W-1:0]              rq_data;
  logic [NUM_REQ-1:0]             rq_done;

  logic                           mem_req;
  logic [ADDR_W-1:0]              mem_addr;
  logic [SZ_W-1:0]                mem_size;
  logic                           mem_valid;
  logic [DATA_W-1:0]              mem_data;
  logic                           mem_done;

  modport slave (
    input  rq_req, rq_addr, rq_size, mem_valid, mem_data, mem_done,
    output rq_valid, rq_data, rq_done, mem_req, mem_addr, mem_size
  );

  modport master (
    output rq_req, rq_addr, rq_size, mem_valid, mem_data, mem_done,
    input  rq_valid, rq_data, rq_done, mem_req, mem_addr, mem_size
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active request at or after ptr_i, wrapping.
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             vld_o,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    vld_o     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o           = 1'b1;
        gnt_idx_o       = cand;
        gnt_oh_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM read channel among several cache requesters.
// Optional streaming watchdog is compiled in when RD_ARB_TIMEOUT_EN is defined.
module sdram_read_arbiter
  import sdram_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_TRANS = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  sdram_read_arbiter_if.slave bus,
  output logic                err
);

  localparam int unsigned SZ_W  = $clog2(MAX_TRANS);
  localparam int unsigned IDX_W = cnt_w(NUM_REQ);
  localparam int unsigned CNT_W = SZ_W + 1;

  if (NUM_REQ == 0 || MAX_TRANS < 2 || TIMEOUT == 0) begin : g_bad_params
    $error("sdram_read_arbiter: NUM_REQ and TIMEOUT must be nonzero, MAX_TRANS at least 2");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SZ_W-1:0]    size_q, size_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   beats;
  logic               err_q, err_d;

  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               wd_expired;

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i    (bus.rq_req),
    .ptr_i    (ptr_q),
    .vld_o    (pick_vld),
    .gnt_oh_o (pick_oh),
    .gnt_idx_o(pick_idx)
  );

`ifdef RD_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = cnt_w(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts cycles spent in STREAM; cleared everywhere else.
  assign wd_d       = (state_q == ST_STREAM) ? wd_q + WD_W'(1) : '0;
  assign wd_expired = (state_q == ST_STREAM) && (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Beats seen including one arriving alongside mem_done.
  assign beats = cnt_q + CNT_W'(bus.mem_valid);

  always_comb begin
    state_d  = state_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_oh_d = pick_oh;
          ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          addr_d   = bus.rq_addr[pick_idx];
          size_d   = bus.rq_size[pick_idx];
          cnt_d    = '0;
          if (bus.rq_size[pick_idx] == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_STREAM;
      ST_STREAM: begin
        if (bus.mem_valid && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_done) begin
          state_d = ST_DONE;
          if (beats != CNT_W'(size_q)) err_d = 1'b1;
        end else if (wd_expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Responses with no transaction in flight are protocol errors.
    if ((state_q != ST_STREAM) && (bus.mem_valid || bus.mem_done)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_oh_q <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_req  = (state_q == ST_ISSUE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_size = size_q;
  assign bus.rq_valid = ((state_q == ST_STREAM) && bus.mem_valid) ? gnt_oh_q : '0;
  assign bus.rq_data  = (state_q == ST_STREAM) ? bus.mem_data : '0;
  assign bus.rq_done  = (state_q == ST_DONE) ? gnt_oh_q : '0;
  assign err          = err_q;

endmodule
